// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
//
// Two-stage pipelined 32-bit adder with valid/ready handshakes on both sides.
// The carry chain is cut at bit 16 so that no cycle adds more than 17 bits:
//   S1: low half    A[15:0]  + B[15:0]  + carry_in -> lo_sum, c16
//   S2: high half   A[31:16] + B[31:16] + c16      -> out, carry_out, overflow
//
// Ports
//   clk        in   1   sole clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   in_valid   in   1   upstream operand set valid
//   in_ready   out  1   block accepts an operand set this cycle
//   input1     in   32  addend A
//   input2     in   32  addend B
//   carry_in   in   1   carry into bit 0
//   out_valid  out  1   output registers hold a valid result
//   out_ready  in   1   downstream accepts the result this cycle
//   out        out  32  registered sum A+B+carry_in mod 2^32
//   carry_out  out  1   carry out of bit 31
//   overflow   out  1   signed two's-complement overflow
// ---------------------------------------------------------------------------
module pipelined_adder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  input  logic        carry_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        carry_out,
  output logic        overflow
);

  // Stage-1 registers: low-half sum, its carry, and the untouched high
  // halves (bit 15 of each high half is A[31]/B[31], used for overflow).
  logic        s1_valid;
  logic [15:0] s1_lo_sum;
  logic        s1_c16;
  logic [15:0] s1_a_hi;
  logic [15:0] s1_b_hi;

  // Handshake control.
  logic s2_en;    // output register may load this cycle
  logic s1_adv;   // S1 content moves into S2 this cycle
  logic in_xfer;  // operand set accepted this cycle

  // Combinational halves of the adder; each is at most 17 bits wide.
  logic [16:0] lo_sum;
  logic [16:0] hi_sum;

  // The output register can take new data when it is empty or being drained.
  // in_ready looks through S2 so a full pipeline keeps streaming at one
  // operand set per cycle while out_ready is high.
  assign s2_en    = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_en;
  assign in_ready = !reset && (!s1_valid || s2_en);
  assign in_xfer  = in_valid && in_ready;

  assign lo_sum = {1'b0, input1[15:0]} + {1'b0, input2[15:0]} + {16'd0, carry_in};
  assign hi_sum = {1'b0, s1_a_hi} + {1'b0, s1_b_hi} + {16'd0, s1_c16};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // NOTE: S1 payload has no reset; s1_valid qualifies it, and leaving the
  // data registers out of reset keeps the reset net off the datapath.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_lo_sum <= lo_sum[15:0];
      s1_c16    <= lo_sum[16];
      s1_a_hi   <= input1[31:16];
      s1_b_hi   <= input2[31:16];
    end
  end

  // Output stage. The result fields are reset because they are visible on
  // the ports and must read zero during reset. When S2 is enabled but S1 is
  // empty, only out_valid drops; the stale data stays put.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out       <= {hi_sum[15:0], s1_lo_sum};
        carry_out <= hi_sum[16];
        // Same-sign operands whose sum flips sign overflowed.
        overflow  <= (s1_a_hi[15] == s1_b_hi[15]) && (hi_sum[15] != s1_a_hi[15]);
      end
    end
  end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 No parameters; datapath width fixed at 32 bits, split into 16-bit low and high halves.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream operand set valid.
REQ-005 in_ready  output  1  block can accept an operand set this cycle.
REQ-006 input1  input  32  addend A.
REQ-007 input2  input  32  addend B.
REQ-008 carry_in  input  1  carry into bit 0.
REQ-009 out_valid  output  1  result registers hold a valid result.
REQ-010 out_ready  input  1  downstream accepts result this cycle.
REQ-011 out  output  32  registered sum A+B+carry_in, modulo 2^32.
REQ-012 carry_out  output  1  carry out of bit 31.
REQ-013 overflow  output  1  signed two's-complement overflow.

Function
REQ-014 Input transfer occurs on a clock edge with in_valid && in_ready; output transfer occurs with out_valid && out_ready.
REQ-015 Two register stages: S1 holds low-half sum [15:0], carry c16 out of bit 15, high halves of A and B, and A[31]/B[31]; S2 is the output register set.
REQ-016 S1 computes A[15:0]+B[15:0]+carry_in; S2 computes A[31:16]+B[31:16]+c16 and concatenates it with the S1 low sum.
REQ-017 No path may add more than 17 bits in one cycle; the full 32-bit carry chain is never combinational.
REQ-018 Latency: result appears on out_valid exactly 2 cycles after input transfer when out_ready is held high.
REQ-019 Throughput: one operand set per cycle sustained when out_ready is high.
REQ-020 S2 advance enable = !out_valid || out_ready; S1 advances into S2 only when S1 valid and S2 advance enable.
REQ-021 in_ready = !reset && (!s1_valid || S2 advance enable); combinational from out_ready is permitted.
REQ-022 While out_valid && !out_ready: out, carry_out and overflow shall hold stable, with no loss and no duplication.
REQ-023 S1 full, S2 stalled: in_ready=0; input1/input2/carry_in are ignored.
REQ-024 S2 drained while S1 full and new input valid: S1 to S2 and input to S1 in the same cycle.
REQ-025 out_valid falls after an output transfer only if no S1 data moves into S2 that cycle.
REQ-026 overflow = (A[31]==B[31]) && (out[31]!=A[31]).
REQ-027 carry_out = bit 32 of the full 33-bit sum including carry_in.
REQ-028 Results leave in strict acceptance order.
REQ-029 Inputs are sampled only on transfer; upstream may change operands freely when not transferring.

Reset
REQ-030 While reset is high: s1_valid=0, out_valid=0, out=0, carry_out=0, overflow=0, in_ready=0.
REQ-031 First cycle after reset is deasserted: in_ready=1, out_valid=0.
REQ-032 Reset asserted mid-operation discards all in-flight data in both stages; no result for those operands ever appears.
REQ-033 Reset takes priority over any simultaneous input or output transfer.

Verification
REQ-034 0x0000FFFF + 0x00000001, carry_in=0, out_ready=1 -> 2 cycles later out=0x00010000, carry_out=0, overflow=0 (exercises c16 carry).
REQ-035 0x7FFFFFFF + 0x00000001 -> out=0x80000000, overflow=1, carry_out=0; and 0xFFFFFFFF + 0x00000000 with carry_in=1 -> out=0x00000000, carry_out=1, overflow=0.
REQ-036 Three back-to-back inputs (1+1, 2+2, 3+3) with out_ready=0 for 4 cycles: check in_ready=0 after two accepted; check out=0x2 held stable; then release out_ready -> 0x2, 0x4, 0x6 in order, each exactly once.
REQ-037 Both stages full, reset pulsed for one cycle -> next cycle out_valid=0, out=0; check in_ready=1 the cycle after reset deasserts; check no stale result ever emitted.
REQ-038 10,000 random operands and carry_in, random in_valid and out_ready (50%) -> every result matches a 33-bit reference model, in order; overflow matches REQ-026.
REQ-039 Simultaneous output transfer and input transfer with S1 full -> no bubble; out_valid stays 1 and the next result follows on the next cycle.
